// File: rtl/ice51_loader_ctrl_pkg.sv
// Shared definitions for the ice51 boot loader: FSM state encoding,
// checksum width and the modulo-256 checksum accumulate step.
package ice51_loader_ctrl_pkg;

    // Loader phases: receive code bytes, report checksum, release the CPU
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SUM  = 2'd1,
        ST_RUN  = 2'd2
    } ldr_state_t;

    // Checksum is a plain byte-wide running sum
    localparam int SUM_W = 8;

    // Add one received byte into the running checksum (wraps naturally)
    function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] acc,
                                                 input logic [7:0]       data);
        return acc + SUM_W'(data);
    endfunction

endpackage

// File: rtl/ice51_loader_ctrl.sv
// Boot loader controller for the ice51 core. After reset it copies MEM_SIZE
// bytes from the UART into code memory, transmits their byte checksum, then
// releases the CPU and hands code-memory addressing and UART TX to it.
// With i_preload set during reset the load and checksum are skipped.
module ice51_loader_ctrl
    import ice51_loader_ctrl_pkg::*;
#(
    parameter int MEM_SIZE = 512,
    parameter int ADDR_W   = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_preload,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_tx_valid,
    input  logic [7:0]        i_cpu_tx_data,
    input  logic              i_tx_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_cpu_rst,
    output logic              o_loading
);

    // Index of the final byte; accepting it ends the load without advancing
    // the pointer, so address 0 can never be revisited.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    ldr_state_t        state_reg,    state_next;
    logic [ADDR_W-1:0] wr_ptr_reg,   wr_ptr_next;
    logic [ADDR_W-1:0] waddr_reg,    waddr_next;
    logic [SUM_W-1:0]  sum_reg,      sum_next;
    logic              we_reg,       we_next;
    logic [7:0]        wdata_reg,    wdata_next;
    logic              tx_valid_reg, tx_valid_next;
    logic [7:0]        tx_data_reg,  tx_data_next;
    logic              cpu_rst_reg,  cpu_rst_next;
    logic              loading_reg,  loading_next;

    // State and datapath registers; reset chooses LOAD or RUN from i_preload
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= i_preload ? ST_RUN : ST_LOAD;
            wr_ptr_reg   <= '0;
            waddr_reg    <= '0;
            sum_reg      <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= 8'h00;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            cpu_rst_reg  <= ~i_preload;
            loading_reg  <= ~i_preload;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            waddr_reg    <= waddr_next;
            sum_reg      <= sum_next;
            we_reg       <= we_next;
            wdata_reg    <= wdata_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
            cpu_rst_reg  <= cpu_rst_next;
            loading_reg  <= loading_next;
        end
    end

    // Next-state and registered-output logic for the LOAD -> SUM -> RUN flow
    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        waddr_next    = waddr_reg;
        sum_next      = sum_reg;
        we_next       = 1'b0;
        wdata_next    = wdata_reg;
        tx_valid_next = tx_valid_reg;
        tx_data_next  = tx_data_reg;
        cpu_rst_next  = cpu_rst_reg;

        case (state_reg)
            ST_LOAD: begin
                cpu_rst_next  = 1'b1;
                tx_valid_next = 1'b0;
                if (i_rx_valid) begin
                    we_next    = 1'b1;
                    waddr_next = wr_ptr_reg;
                    wdata_next = i_rx_data;
                    sum_next   = sum_add(sum_reg, i_rx_data);
                    if (wr_ptr_reg == LAST_ADDR) begin
                        // Last byte: checksum (including it) goes out next cycle
                        state_next    = ST_SUM;
                        tx_valid_next = 1'b1;
                        tx_data_next  = sum_next;
                    end else begin
                        wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
                    end
                end
            end
            ST_SUM: begin
                // Hold the checksum byte until the transmitter takes it
                cpu_rst_next = 1'b1;
                if (i_tx_ready) begin
                    state_next    = ST_RUN;
                    tx_valid_next = 1'b0;
                    cpu_rst_next  = 1'b0;
                end
            end
            ST_RUN: begin
                cpu_rst_next  = 1'b0;
                tx_valid_next = 1'b0;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase

        loading_next = (state_next == ST_LOAD);
    end

    // Only the address and TX muxes are combinational; the CPU owns them in RUN
    always_comb begin
        if (state_reg == ST_RUN) begin
            o_mem_addr = i_cpu_addr;
            o_tx_valid = i_cpu_tx_valid;
            o_tx_data  = i_cpu_tx_data;
        end else begin
            o_mem_addr = waddr_reg;
            o_tx_valid = tx_valid_reg;
            o_tx_data  = tx_data_reg;
        end
    end

    assign o_mem_wdata = wdata_reg;
    assign o_mem_we    = we_reg;
    assign o_cpu_rst   = cpu_rst_reg;
    assign o_loading   = loading_reg;

endmodule

// File: tb/tb_ice51_loader_ctrl.sv
// Directed bench for ice51_loader_ctrl: full load with checksum, extra bytes,
// TX backpressure, CPU passthrough, reset mid-load, preload and reset priority.
module tb_ice51_loader_ctrl;

    localparam int MEM_SIZE = 512;
    localparam int ADDR_W   = 9;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_preload = 1'b0;
    logic              i_rx_valid = 1'b0;
    logic [7:0]        i_rx_data = 8'h00;
    logic [ADDR_W-1:0] i_cpu_addr = '0;
    logic              i_cpu_tx_valid = 1'b0;
    logic [7:0]        i_cpu_tx_data = 8'h00;
    logic              i_tx_ready = 1'b0;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;
    logic              o_mem_we;
    logic              o_tx_valid;
    logic [7:0]        o_tx_data;
    logic              o_cpu_rst;
    logic              o_loading;

    int check_cnt = 0;
    int pass_cnt  = 0;

    ice51_loader_ctrl #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_preload      (i_preload),
        .i_rx_valid     (i_rx_valid),
        .i_rx_data      (i_rx_data),
        .i_cpu_addr     (i_cpu_addr),
        .i_cpu_tx_valid (i_cpu_tx_valid),
        .i_cpu_tx_data  (i_cpu_tx_data),
        .i_tx_ready     (i_tx_ready),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_we       (o_mem_we),
        .o_tx_valid     (o_tx_valid),
        .o_tx_data      (o_tx_data),
        .o_cpu_rst      (o_cpu_rst),
        .o_loading      (o_loading)
    );

    always #5 i_clk = ~i_clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset(input logic preload);
        i_rst      = 1'b1;
        i_preload  = preload;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b0;
        tick();
        tick();
        i_rst     = 1'b0;
        i_preload = 1'b0;
    endtask

    // One received byte: the write must appear for exactly one cycle
    task automatic send_byte(input int idx, input logic [7:0] d);
        logic [ADDR_W-1:0] ea;
        ea = idx[ADDR_W-1:0];
        i_rx_valid = 1'b1;
        i_rx_data  = d;
        tick();
        i_rx_valid = 1'b0;
        check_cnt++;
        if (o_mem_we !== 1'b1 || o_mem_addr !== ea || o_mem_wdata !== d)
            $display("FAIL write[%0d]: we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                     idx, o_mem_we, o_mem_addr, o_mem_wdata, ea, d);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (o_mem_we !== 1'b0)
            $display("FAIL write_pulse[%0d]: we=%b, want 0", idx, o_mem_we);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        check_cnt++;
        if (o_cpu_rst !== 1'b1 || o_loading !== 1'b1 || o_mem_we !== 1'b0 ||
            o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 || o_mem_addr !== 9'h000)
            $display("FAIL reset_state: cpu_rst=%b loading=%b we=%b txv=%b txd=%h addr=%h, want 1 1 0 0 00 000",
                     o_cpu_rst, o_loading, o_mem_we, o_tx_valid, o_tx_data, o_mem_addr);
        else pass_cnt++;
        $display("test_reset: done");
    endtask

    task automatic test_full_load();
        // CPU TX request must be blocked while loading
        i_cpu_tx_valid = 1'b1;
        i_cpu_tx_data  = 8'h33;
        for (int i = 0; i < MEM_SIZE; i++) begin
            send_byte(i, i[7:0]);
            if (i == 0) begin
                check_cnt++;
                if (o_tx_valid !== 1'b0 || o_cpu_rst !== 1'b1 || o_loading !== 1'b1)
                    $display("FAIL load_block: txv=%b cpu_rst=%b loading=%b, want 0 1 1",
                             o_tx_valid, o_cpu_rst, o_loading);
                else pass_cnt++;
            end
        end
        i_cpu_tx_valid = 1'b0;
        // sum of 0..255 twice = 0x7F80*2 -> 0x00 mod 256
        check_cnt++;
        if (o_loading !== 1'b0 || o_tx_valid !== 1'b1 || o_tx_data !== 8'h00 ||
            o_cpu_rst !== 1'b1 || o_mem_addr !== 9'h1FF)
            $display("FAIL full_load_sum: loading=%b txv=%b txd=%h cpu_rst=%b addr=%h, want 0 1 00 1 1ff",
                     o_loading, o_tx_valid, o_tx_data, o_cpu_rst, o_mem_addr);
        else pass_cnt++;
        $display("test_full_load: 512 bytes sent, checksum byte presented");
    endtask

    task automatic test_extra_bytes();
        for (int k = 0; k < 3; k++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'hEE;
            tick();
            i_rx_valid = 1'b0;
            check_cnt++;
            if (o_mem_we !== 1'b0 || o_mem_addr !== 9'h1FF)
                $display("FAIL extra_byte[%0d]: we=%b addr=%h, want we=0 addr=1ff",
                         k, o_mem_we, o_mem_addr);
            else pass_cnt++;
            tick();
        end
        $display("test_extra_bytes: 3 extra pulses ignored");
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        i_tx_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h00 || o_cpu_rst !== 1'b1) bad++;
        end
        check_cnt++;
        if (bad != 0)
            $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
        else pass_cnt++;
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        check_cnt++;
        if (o_cpu_rst !== 1'b0 || o_tx_valid !== 1'b0 || o_mem_we !== 1'b0)
            $display("FAIL handshake_release: cpu_rst=%b txv=%b we=%b, want 0 0 0",
                     o_cpu_rst, o_tx_valid, o_mem_we);
        else pass_cnt++;
        $display("test_backpressure: 100 stalled cycles then handshake");
    endtask

    task automatic test_run_passthrough();
        i_cpu_addr     = 9'h1A5;
        i_cpu_tx_valid = 1'b1;
        i_cpu_tx_data  = 8'h55;
        #1;
        check_cnt++;
        if (o_mem_addr !== 9'h1A5 || o_tx_valid !== 1'b1 || o_tx_data !== 8'h55 || o_mem_we !== 1'b0)
            $display("FAIL run_pass: addr=%h txv=%b txd=%h we=%b, want 1a5 1 55 0",
                     o_mem_addr, o_tx_valid, o_tx_data, o_mem_we);
        else pass_cnt++;
        i_cpu_addr = 9'h00C;
        #1;
        check_cnt++;
        if (o_mem_addr !== 9'h00C)
            $display("FAIL run_addr_comb: addr=%h, want 00c", o_mem_addr);
        else pass_cnt++;
        // UART bytes are ignored once running
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h77;
        tick();
        i_rx_valid = 1'b0;
        check_cnt++;
        if (o_mem_we !== 1'b0 || o_cpu_rst !== 1'b0)
            $display("FAIL run_rx_ignored: we=%b cpu_rst=%b, want 0 0", o_mem_we, o_cpu_rst);
        else pass_cnt++;
        i_cpu_tx_valid = 1'b0;
        i_cpu_addr     = '0;
        $display("test_run_passthrough: addr 1a5 / tx 55 passed through");
    endtask

    task automatic test_reset_midload();
        apply_reset(1'b0);
        for (int i = 0; i < 200; i++) send_byte(i, 8'hAA);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_cnt++;
        if (o_loading !== 1'b1 || o_cpu_rst !== 1'b1 || o_mem_addr !== 9'h000 || o_mem_we !== 1'b0)
            $display("FAIL midload_reset: loading=%b cpu_rst=%b addr=%h we=%b, want 1 1 000 0",
                     o_loading, o_cpu_rst, o_mem_addr, o_mem_we);
        else pass_cnt++;
        for (int i = 0; i < MEM_SIZE; i++) send_byte(i, 8'h01);
        // 512 * 1 = 0x200 -> 0x00; any residue of 0xAA bytes would show here
        check_cnt++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h00 || o_loading !== 1'b0)
            $display("FAIL reload_sum: txv=%b txd=%h loading=%b, want 1 00 0",
                     o_tx_valid, o_tx_data, o_loading);
        else pass_cnt++;
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        check_cnt++;
        if (o_cpu_rst !== 1'b0)
            $display("FAIL reload_release: cpu_rst=%b, want 0", o_cpu_rst);
        else pass_cnt++;
        $display("test_reset_midload: reset at byte 200, reload of 512 x 01");
    endtask

    task automatic test_preload();
        int writes;
        apply_reset(1'b1);
        check_cnt++;
        if (o_cpu_rst !== 1'b0 || o_loading !== 1'b0 || o_mem_we !== 1'b0 || o_tx_valid !== 1'b0)
            $display("FAIL preload_state: cpu_rst=%b loading=%b we=%b txv=%b, want 0 0 0 0",
                     o_cpu_rst, o_loading, o_mem_we, o_tx_valid);
        else pass_cnt++;
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = 8'h5A;
            tick();
            i_rx_valid = 1'b0;
            if (o_mem_we !== 1'b0 || o_tx_valid !== 1'b0) writes++;
        end
        check_cnt++;
        if (writes != 0)
            $display("FAIL preload_no_write: %0d write/tx cycles, want 0", writes);
        else pass_cnt++;
        $display("test_preload: CPU released straight from reset");
    endtask

    task automatic test_reset_priority();
        i_rst      = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hC3;
        tick();
        i_rst      = 1'b0;
        i_rx_valid = 1'b0;
        check_cnt++;
        if (o_mem_we !== 1'b0 || o_loading !== 1'b1 || o_cpu_rst !== 1'b1)
            $display("FAIL reset_priority: we=%b loading=%b cpu_rst=%b, want 0 1 1",
                     o_mem_we, o_loading, o_cpu_rst);
        else pass_cnt++;
        send_byte(0, 8'h3C);
        $display("test_reset_priority: byte during reset dropped, next lands at 0");
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_extra_bytes();
        test_backpressure();
        test_run_passthrough();
        test_reset_midload();
        test_preload();
        test_reset_priority();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/ice51_loader_ctrl.md
ICE51_LOADER_CTRL -- requirements
Module: ice51_loader_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, number of code-memory bytes loaded at boot.
REQ-002 SHALL have parameter ADDR_W, default 9, code-memory address width; it equals clog2(MEM_SIZE).
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port i_preload  input  1  sampled in reset; 1 skips the load and the checksum and starts in RUN.
REQ-006 SHALL have port i_rx_valid  input  1  single-cycle strobe meaning a UART byte was received.
REQ-007 SHALL have port i_rx_data  input  8  received byte, valid with i_rx_valid.
REQ-008 SHALL have port i_cpu_addr  input  ADDR_W  CPU fetch address.
REQ-009 SHALL have port i_cpu_tx_valid  input  1  CPU UART transmit request.
REQ-010 SHALL have port i_cpu_tx_data  input  8  CPU UART transmit byte.
REQ-011 SHALL have port i_tx_ready  input  1  UART transmitter can accept a byte.
REQ-012 SHALL have port o_mem_addr  output  ADDR_W  code-memory address, muxed between loader and CPU.
REQ-013 SHALL have port o_mem_wdata  output  8  code-memory write data.
REQ-014 SHALL have port o_mem_we  output  1  code-memory write enable.
REQ-015 SHALL have port o_tx_valid  output  1  UART transmit request.
REQ-016 SHALL have port o_tx_data  output  8  UART transmit byte.
REQ-017 SHALL have port o_cpu_rst  output  1  holds the CPU in reset, active-high.
REQ-018 SHALL have port o_loading  output  1  high in LOAD.

Function
REQ-019 SHALL implement FSM states LOAD, SUM, RUN.
REQ-020 LOAD: each i_rx_valid SHALL assert o_mem_we for exactly 1 cycle with o_mem_addr = wr_ptr and o_mem_wdata = i_rx_data (registered, latency 1 cycle), then increment wr_ptr.
REQ-021 LOAD SHALL accumulate sum = (sum + byte) mod 256 for every byte accepted.
REQ-022 After byte index MEM_SIZE-1 is accepted, the FSM SHALL go LOAD->SUM; wr_ptr SHALL NOT wrap or overwrite address 0.
REQ-023 SUM: o_tx_valid = 1 and o_tx_data = sum SHALL be held until a rising edge with i_tx_ready = 1, then the FSM goes to RUN.
REQ-024 In LOAD and SUM, o_cpu_rst = 1 and i_cpu_tx_valid SHALL be blocked.
REQ-025 RUN: o_cpu_rst = 0 from the first RUN cycle; o_mem_addr = i_cpu_addr (combinational); o_mem_we = 0; o_tx_valid and o_tx_data pass i_cpu_tx_valid and i_cpu_tx_data through.
REQ-026 RUN SHALL be terminal until i_rst; i_rx_valid SHALL be ignored in RUN and SUM.
REQ-027 An i_rx_valid on the same cycle as LOAD->SUM SHALL complete the last write; no other byte is accepted after the last write.
REQ-028 In LOAD and SUM, o_mem_addr = wr_ptr (registered address of the pending or last write).

Reset
REQ-029 i_rst high at a clock edge SHALL force: state = LOAD (RUN if i_preload = 1), wr_ptr = 0, sum = 0, o_mem_we = 0, o_tx_valid = 0, o_tx_data = 0, o_cpu_rst = 1 (0 if preload), o_loading = 1 (0 if preload).
REQ-030 Reset mid-load or mid-SUM SHALL discard progress; the next load restarts at address 0 with sum 0.
REQ-031 i_rst SHALL have priority over every other input at the same edge.

Structure
REQ-032 State encoding and the checksum width constant SHALL live in the shared ice51 package.
REQ-033 The block SHALL be a single module with no sub-modules; the byte counter and checksum are inline registers.
REQ-034 o_mem_addr and the TX mux SHALL be the only combinational outputs; all others are registered.

Verification
REQ-035 Full load: send 512 bytes with value (i mod 256) -> 512 single-cycle writes to addresses 0..511 with the matching data; checksum 0x00 transmitted; o_cpu_rst falls 1 cycle after the TX handshake.
REQ-036 Backpressure: i_tx_ready held 0 for 100 cycles in SUM -> o_tx_valid and o_tx_data stable for all 100 cycles; o_cpu_rst stays 1 until the cycle after ready.
REQ-037 Preload: i_preload = 1 during reset -> o_cpu_rst = 0 immediately after reset, no writes, no checksum byte.
REQ-038 Reset at byte 200, then reload of 512 bytes of 0x01 -> first write goes to address 0; checksum is 0x00 (512 mod 256); no residue from the earlier load.
REQ-039 Extra bytes: 3 i_rx_valid pulses after byte 511 -> no writes; address 0 unchanged.
REQ-040 RUN passthrough: i_cpu_addr = 0x1A5 and i_cpu_tx_valid = 1 with data 0x55 -> o_mem_addr = 0x1A5 and o_tx_data = 0x55 in the same cycle; o_mem_we = 0.
